// File: rtl/sser_pkg.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | Module  : sser_pkg                                                     |
// | Brief   : Shared types and constants for the sser_tx serial block.     |
// |           SSER_TX_PARITY_EN adds the PARITY state and frame length.    |
// | Revision: 1.0                                                          |
// +------------------------------------------------------------------------+
package sser_pkg;

`ifdef SSER_TX_PARITY_EN
    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_SHIFT  = 3'd2,
        ST_STOP   = 3'd3,
        ST_PARITY = 3'd4
    } sser_state_e;

    localparam int FRAME_BITS = 11;
`else
    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_SHIFT  = 3'd2,
        ST_STOP   = 3'd3
    } sser_state_e;

    localparam int FRAME_BITS = 10;
`endif

    localparam logic [3:0] REG_TXDATA = 4'h0;
    localparam logic [3:0] REG_CTRL   = 4'h1;

    // Bus window: BA13 low, BA12 high
    localparam logic WIN_BA13 = 1'b0;
    localparam logic WIN_BA12 = 1'b1;

    localparam int DATA_BITS = 8;

    function automatic int frame_cycles(input int clk_div);
        return FRAME_BITS * clk_div;
    endfunction

endpackage
`default_nettype wire

// File: rtl/sser_baud_tick.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | Module  : sser_baud_tick                                               |
// | Brief   : Bit-period divider; tick marks the last cycle of each bit.   |
// | Revision: 1.0                                                          |
// +------------------------------------------------------------------------+
module sser_baud_tick #(
    parameter int CLK_DIV = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic restart,
    output logic tick
);

    localparam int              CW   = $clog2(CLK_DIV);
    localparam logic [CW-1:0]   LAST = CW'(CLK_DIV - 1);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    assign tick = (cnt_q == LAST);

    always_comb begin
        cnt_d = cnt_q + 1'b1;
        if (restart || tick) begin
            cnt_d = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule
`default_nettype wire

// File: rtl/sser_tx.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | Module  : sser_tx                                                      |
// | Brief   : Bus-mapped 8N1 serial transmitter with sticky overrun flag.  |
// |           Define SSER_TX_PARITY_EN for an even-parity bit.             |
// | Revision: 1.0                                                          |
// +------------------------------------------------------------------------+
module sser_tx
    import sser_pkg::*;
#(
    parameter int CLK_DIV = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        sser,
    input  logic [13:4] ba,
    input  logic        br_w,
    input  logic [7:0]  bd,
    output logic        sd_tx,
    output logic        busy,
    output logic        ovr
);

    localparam logic [2:0] LAST_BIT = 3'(DATA_BITS - 1);

    sser_state_e state_q;
    logic        sd_tx_q;
    logic        busy_q;
    logic        ovr_q;
    logic [2:0]  bitcnt_q;
    logic [7:0]  shreg_q;
`ifdef SSER_TX_PARITY_EN
    logic        par_q;
`endif

    logic wstb;
    logic wr_tx;
    logic wr_ctrl;
    logic tick;
    logic tx_ok;
    logic accept;
    logic ovr_set;
    logic ovr_clr;
    logic restart;
    logic unused_ba;

    assign unused_ba = ^ba[11:8];

    assign wstb    = ~sser & (ba[13] == WIN_BA13) & (ba[12] == WIN_BA12) & ~br_w;
    assign wr_tx   = wstb & (ba[7:4] == REG_TXDATA);
    assign wr_ctrl = wstb & (ba[7:4] == REG_CTRL);

    // Final STOP cycle counts as free so frames can abut with no idle gap
    assign tx_ok   = (state_q == ST_IDLE) | ((state_q == ST_STOP) & tick);
    assign accept  = wr_tx & tx_ok;
    assign ovr_set = wr_tx & ~tx_ok;
    assign ovr_clr = wr_ctrl & bd[0];
    assign restart = accept | (state_q == ST_IDLE);

    sser_baud_tick #(
        .CLK_DIV (CLK_DIV)
    ) u_baud (
        .clk     (clk),
        .rst     (rst),
        .restart (restart),
        .tick    (tick)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            sd_tx_q  <= 1'b1;
            busy_q   <= 1'b0;
            ovr_q    <= 1'b0;
            bitcnt_q <= '0;
            shreg_q  <= '0;
`ifdef SSER_TX_PARITY_EN
            par_q    <= 1'b0;
`endif
        end else begin
            if (ovr_set) begin
                ovr_q <= 1'b1;
            end else if (ovr_clr) begin
                ovr_q <= 1'b0;
            end

            if (accept) begin
                state_q  <= ST_START;
                sd_tx_q  <= 1'b0;
                busy_q   <= 1'b1;
                shreg_q  <= bd;
                bitcnt_q <= '0;
`ifdef SSER_TX_PARITY_EN
                par_q    <= ^bd;
`endif
            end else if (tick) begin
                case (state_q)
                    ST_START: begin
                        state_q <= ST_SHIFT;
                        sd_tx_q <= shreg_q[0];
                        shreg_q <= shreg_q >> 1;
                    end
                    ST_SHIFT: begin
                        if (bitcnt_q == LAST_BIT) begin
`ifdef SSER_TX_PARITY_EN
                            state_q <= ST_PARITY;
                            sd_tx_q <= par_q;
`else
                            state_q <= ST_STOP;
                            sd_tx_q <= 1'b1;
`endif
                        end else begin
                            bitcnt_q <= bitcnt_q + 1'b1;
                            sd_tx_q  <= shreg_q[0];
                            shreg_q  <= shreg_q >> 1;
                        end
                    end
`ifdef SSER_TX_PARITY_EN
                    ST_PARITY: begin
                        state_q <= ST_STOP;
                        sd_tx_q <= 1'b1;
                    end
`endif
                    default: begin
                        state_q <= ST_IDLE;
                        sd_tx_q <= 1'b1;
                        busy_q  <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign sd_tx = sd_tx_q;
    assign busy  = busy_q;
    assign ovr   = ovr_q;

endmodule
`default_nettype wire

// File: tb/tb_sser_tx.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | Module  : tb_sser_tx                                                   |
// | Brief   : Self-checking bench for sser_tx against a line-level model.  |
// | Revision: 1.0                                                          |
// +------------------------------------------------------------------------+
module tb_sser_tx;

`ifdef SSER_TX_PARITY_EN
    localparam int CLK_DIV = 2;
    localparam int FB      = 11;
`else
    localparam int CLK_DIV = 4;
    localparam int FB      = 10;
`endif
    localparam int FLEN = FB * CLK_DIV;

    logic        clk = 1'b0;
    logic        rst;
    logic        sser;
    logic [13:4] ba;
    logic        br_w;
    logic [7:0]  bd;
    logic        sd_tx;
    logic        busy;
    logic        ovr;

    sser_tx #(.CLK_DIV(CLK_DIV)) dut (
        .clk   (clk),
        .rst   (rst),
        .sser  (sser),
        .ba    (ba),
        .br_w  (br_w),
        .bd    (bd),
        .sd_tx (sd_tx),
        .busy  (busy),
        .ovr   (ovr)
    );

    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_pass = 0;

    // Model: expected line level for each remaining cycle of queued frames
    bit m_line[$];
    bit m_ovr  = 1'b0;
    bit m_sd   = 1'b1;
    bit m_busy = 1'b0;

    function automatic void push_frame(input logic [7:0] d);
        bit bits[$];
        bits.push_back(1'b0);
        for (int i = 0; i < 8; i++) bits.push_back(d[i]);
`ifdef SSER_TX_PARITY_EN
        bits.push_back(^d);
`endif
        bits.push_back(1'b1);
        foreach (bits[i])
            for (int k = 0; k < CLK_DIV; k++) m_line.push_back(bits[i]);
    endfunction

    task automatic step();
        logic wstb;
        if (m_line.size() > 0) void'(m_line.pop_front());
        wstb = !sser && !ba[13] && ba[12] && !br_w;
        if (rst) begin
            m_line.delete();
            m_ovr = 1'b0;
        end else if (wstb && ba[7:4] == 4'h0) begin
            if (m_line.size() == 0) push_frame(bd);
            else m_ovr = 1'b1;
        end else if (wstb && ba[7:4] == 4'h1 && bd[0]) begin
            m_ovr = 1'b0;
        end
        @(posedge clk);
        #1;
        m_busy = (m_line.size() != 0);
        m_sd   = m_busy ? m_line[0] : 1'b1;
    endtask

    task automatic bus_idle();
        sser = 1'b1; ba = '0; br_w = 1'b1; bd = '0;
    endtask

    task automatic wr(input logic [3:0] off, input logic [7:0] d);
        sser = 1'b0; ba = {1'b0, 1'b1, 4'h0, off}; br_w = 1'b0; bd = d;
        step();
        bus_idle();
    endtask

    // One bus cycle that misses the decode in way k
    task automatic illegal(input int k, input logic [3:0] off, input logic [7:0] d);
        sser = 1'b0; ba = {1'b0, 1'b1, 4'h0, off}; br_w = 1'b0; bd = d;
        case (k)
            0:       ba[13] = 1'b1;
            1:       ba[12] = 1'b0;
            2:       br_w = 1'b1;
            3:       sser = 1'b1;
            default: ba[7:4] = 4'h2;
        endcase
        step();
        bus_idle();
    endtask

    task automatic test_reset();
        bus_idle();
        rst = 1'b1;
        step();
        step();
        n_chk++;
        if ({sd_tx, busy, ovr} !== 3'b100)
            $display("FAIL reset_hold got sd/busy/ovr=%b want=100", {sd_tx, busy, ovr});
        else n_pass++;
        rst = 1'b0;
        step();
        n_chk++;
        if ({sd_tx, busy, ovr} !== 3'b100)
            $display("FAIL reset_release got sd/busy/ovr=%b want=100", {sd_tx, busy, ovr});
        else n_pass++;
    endtask

    task automatic test_single();
`ifdef SSER_TX_PARITY_EN
        logic [10:0] exp_bits = 11'b10101001010;
`else
        logic [10:0] exp_bits = 11'b01101001010;
`endif
        int  nbusy = 0;
        logic exp_sd;
        wr(4'h0, 8'hA5);
        for (int c = 0; c < FLEN + 8; c++) begin
            if (busy) nbusy++;
            exp_sd = (c < FLEN) ? exp_bits[c / CLK_DIV] : 1'b1;
            n_chk++;
            if ({sd_tx, busy} !== {exp_sd, c < FLEN})
                $display("FAIL single_a5 cyc=%0d got sd/busy=%b want=%b", c, {sd_tx, busy}, {exp_sd, c < FLEN});
            else n_pass++;
            step();
        end
        n_chk++;
        if (nbusy != FLEN) $display("FAIL single_busy_len got=%0d want=%0d", nbusy, FLEN);
        else n_pass++;
    endtask

    task automatic test_back_to_back();
        int nbusy = 0;
        wr(4'h0, 8'h01);
        for (int c = 0; c < FLEN; c++) begin
            if (busy) nbusy++;
            n_chk++;
            if ({sd_tx, busy, ovr} !== {m_sd, m_busy, m_ovr})
                $display("FAIL b2b_frame1 cyc=%0d got=%b want=%b", c, {sd_tx, busy, ovr}, {m_sd, m_busy, m_ovr});
            else n_pass++;
            if (c < FLEN - 1) step();
        end
        wr(4'h0, 8'h3C);
        n_chk++;
        if ({sd_tx, busy} !== 2'b01) $display("FAIL b2b_start got sd/busy=%b want=01", {sd_tx, busy});
        else n_pass++;
        for (int c = 0; c < FLEN; c++) begin
            if (busy) nbusy++;
            n_chk++;
            if ({sd_tx, busy, ovr} !== {m_sd, m_busy, m_ovr})
                $display("FAIL b2b_frame2 cyc=%0d got=%b want=%b", c, {sd_tx, busy, ovr}, {m_sd, m_busy, m_ovr});
            else n_pass++;
            step();
        end
        n_chk++;
        if (nbusy != 2 * FLEN) $display("FAIL b2b_busy_len got=%0d want=%0d", nbusy, 2 * FLEN);
        else n_pass++;
        n_chk++;
        if ({busy, ovr} !== 2'b00) $display("FAIL b2b_end got busy/ovr=%b want=00", {busy, ovr});
        else n_pass++;
    endtask

    task automatic test_overrun();
        wr(4'h0, 8'h55);
        repeat (9) step();
        wr(4'h0, 8'hFF);
        n_chk++;
        if (ovr !== 1'b1) $display("FAIL ovr_set got=%b want=1", ovr);
        else n_pass++;
        for (int c = 10; c < FLEN + 4; c++) begin
            n_chk++;
            if ({sd_tx, busy, ovr} !== {m_sd, m_busy, m_ovr})
                $display("FAIL ovr_frame cyc=%0d got=%b want=%b", c, {sd_tx, busy, ovr}, {m_sd, m_busy, m_ovr});
            else n_pass++;
            step();
        end
        n_chk++;
        if ({sd_tx, busy, ovr} !== 3'b101) $display("FAIL ovr_no_ff got=%b want=101", {sd_tx, busy, ovr});
        else n_pass++;
        wr(4'h1, 8'hFE);
        n_chk++;
        if (ovr !== 1'b1) $display("FAIL ovr_ctrl_bit0_low got=%b want=1", ovr);
        else n_pass++;
        wr(4'h1, 8'h01);
        n_chk++;
        if (ovr !== 1'b0) $display("FAIL ovr_clear got=%b want=0", ovr);
        else n_pass++;
    endtask

    task automatic test_decode();
        for (int k = 0; k < 5; k++) begin
            illegal(k, 4'h0, 8'hC3);
            step();
            n_chk++;
            if ({sd_tx, busy, ovr} !== 3'b100)
                $display("FAIL decode_idle k=%0d got=%b want=100", k, {sd_tx, busy, ovr});
            else n_pass++;
        end
        wr(4'h0, 8'h11);
        wr(4'h0, 8'h22);
        for (int k = 0; k < 5; k++) begin
            illegal(k, 4'h1, 8'h01);
            n_chk++;
            if ({sd_tx, busy, ovr} !== {m_sd, m_busy, 1'b1})
                $display("FAIL decode_ctrl k=%0d got=%b want=%b", k, {sd_tx, busy, ovr}, {m_sd, m_busy, 1'b1});
            else n_pass++;
        end
        for (int c = 0; c < FLEN; c++) begin
            n_chk++;
            if ({sd_tx, busy, ovr} !== {m_sd, m_busy, m_ovr})
                $display("FAIL decode_frame cyc=%0d got=%b want=%b", c, {sd_tx, busy, ovr}, {m_sd, m_busy, m_ovr});
            else n_pass++;
            step();
        end
        wr(4'h1, 8'h01);
    endtask

    task automatic test_reset_midframe();
        wr(4'h0, 8'h81);
        repeat (4) step();
        wr(4'h0, 8'h99);
        repeat (11) step();
        rst = 1'b1;
        sser = 1'b0; ba = {1'b0, 1'b1, 4'h0, 4'h0}; br_w = 1'b0; bd = 8'h5A;
        step();
        n_chk++;
        if ({sd_tx, busy, ovr} !== 3'b100) $display("FAIL rst_mid got=%b want=100", {sd_tx, busy, ovr});
        else n_pass++;
        rst = 1'b0;
        bus_idle();
        repeat (3) step();
        n_chk++;
        if ({sd_tx, busy, ovr} !== 3'b100) $display("FAIL rst_mid_idle got=%b want=100", {sd_tx, busy, ovr});
        else n_pass++;
        wr(4'h0, 8'h81);
        for (int c = 0; c < FLEN + 2; c++) begin
            n_chk++;
            if ({sd_tx, busy, ovr} !== {m_sd, m_busy, m_ovr})
                $display("FAIL rst_refr cyc=%0d got=%b want=%b", c, {sd_tx, busy, ovr}, {m_sd, m_busy, m_ovr});
            else n_pass++;
            step();
        end
    endtask

`ifdef SSER_TX_PARITY_EN
    task automatic test_parity();
        logic [10:0] exp_bits = 11'b11000001110;
        int   nbusy = 0;
        logic exp_sd;
        wr(4'h0, 8'h07);
        for (int c = 0; c < FLEN + 4; c++) begin
            if (busy) nbusy++;
            exp_sd = (c < FLEN) ? exp_bits[c / CLK_DIV] : 1'b1;
            n_chk++;
            if (sd_tx !== exp_sd) $display("FAIL parity_07 cyc=%0d got=%b want=%b", c, sd_tx, exp_sd);
            else n_pass++;
            step();
        end
        n_chk++;
        if (nbusy != 22) $display("FAIL parity_busy_len got=%0d want=22", nbusy);
        else n_pass++;
    endtask
`endif

    task automatic test_random();
        for (int i = 0; i < 3000; i++) begin
            rst = ($urandom_range(0, 399) == 0);
            if ($urandom_range(0, 5) == 0) begin
                sser = ($urandom_range(0, 7) == 0);
                ba   = {($urandom_range(0, 7) == 0), ($urandom_range(0, 7) != 0), 4'($urandom),
                        ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'($urandom_range(0, 1))};
                br_w = ($urandom_range(0, 7) == 0);
                bd   = 8'($urandom);
            end else begin
                bus_idle();
            end
            step();
            n_chk++;
            if ({sd_tx, busy, ovr} !== {m_sd, m_busy, m_ovr})
                $display("FAIL random cyc=%0d got=%b want=%b", i, {sd_tx, busy, ovr}, {m_sd, m_busy, m_ovr});
            else n_pass++;
        end
        rst = 1'b0;
        bus_idle();
        step();
    endtask

    initial begin
        rst = 1'b1;
        bus_idle();
        test_reset();
        test_single();
        test_back_to_back();
        test_overrun();
        test_decode();
        test_reset_midframe();
`ifdef SSER_TX_PARITY_EN
        test_parity();
`endif
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
`default_nettype wire
